painterengine_gpu_framestreamer: RTL and testbench

//  Parametrised frame-read sequencer for the GPU display path. Walks a WIDTHxHEIGHT viewport at (X0,Y0)

---
 rtl/painterengine_gpu_framestreamer_if.sv | 31 +++
 rtl/painterengine_gpu_framestreamer.sv | 215 +++++++++++++++++++++
 tb/tb_painterengine_gpu_framestreamer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_framestreamer_if.sv
// Reader-side bus of the frame streamer: burst request, enable, completion and FIFO free space.
// The master modport is the sequencer and the slave modport is the DMA reader.
interface painterengine_gpu_framestreamer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
);
  logic [ADDR_W-1:0] reader_address;
  logic [31:0]       reader_length;
  logic              reader_resetn;
  logic              reader_done;
  logic              reader_error;
  logic [CNT_W-1:0]  fifo_empty_count;

  modport master (
    output reader_address,
    output reader_length,
    output reader_resetn,
    input  reader_done,
    input  reader_error,
    input  fifo_empty_count
  );

  modport slave (
    input  reader_address,
    input  reader_length,
    input  reader_resetn,
    output reader_done,
    output reader_error,
    output fifo_empty_count
  );
endinterface

// File: rtl/painterengine_gpu_framestreamer.sv
// Frame-read sequencer that walks a viewport of a pitched framebuffer and issues row-segment bursts.
// Optional ping-pong buffering is enabled by PAINTERENGINE_GPU_FRAMESTREAMER_DOUBLE_BUFFER_EN.
module painterengine_gpu_framestreamer #(
  parameter int ADDR_W      = 32,
  parameter int DIM_W       = 16,
  parameter int BPP_BYTES   = 4,
  parameter int BLOCK_SIZE  = 64,
  parameter int LAUNCH_SIZE = 48,
  parameter int CNT_W       = 8
) (
  input  logic              i_wire_clock,
  input  logic              i_wire_resetn,
  input  logic              i_wire_start,
  input  logic              i_wire_stop,
  input  logic              i_wire_continuous,
  input  logic [ADDR_W-1:0] i_wire_base_address,
`ifdef PAINTERENGINE_GPU_FRAMESTREAMER_DOUBLE_BUFFER_EN
  input  logic [ADDR_W-1:0] i_wire_base_address1,
  output logic              o_wire_buffer_index,
`endif
  input  logic [ADDR_W-1:0] i_wire_stride,
  input  logic [DIM_W-1:0]  i_wire_x0,
  input  logic [DIM_W-1:0]  i_wire_y0,
  input  logic [DIM_W-1:0]  i_wire_width,
  input  logic [DIM_W-1:0]  i_wire_height,
  painterengine_gpu_framestreamer_if.master reader,
  output logic [2:0]        o_wire_state,
  output logic              o_wire_busy,
  output logic              o_wire_frame_done,
  output logic [15:0]       o_wire_frame_count
);

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_CALC1  = 3'b001;
  localparam logic [2:0] ST_CALC2  = 3'b010;
  localparam logic [2:0] ST_WAIT   = 3'b011;
  localparam logic [2:0] ST_STREAM = 3'b100;
  localparam logic [2:0] ST_CHECK  = 3'b101;
  localparam logic [2:0] ST_DONE   = 3'b110;
  localparam logic [2:0] ST_ERROR  = 3'b111;

  logic [2:0]        state_reg, state_next;
  logic [DIM_W-1:0]  x_reg, x_next, y_reg, y_next;
  logic [ADDR_W-1:0] row_off_reg, row_off_next, col_off_reg, col_off_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DIM_W-1:0]  length_reg, length_next;
  logic              frame_done_reg, frame_done_next;
  logic [15:0]       frame_count_reg, frame_count_next;

  logic [ADDR_W-1:0] cfg_base_reg, cfg_stride_reg;
  logic [DIM_W-1:0]  cfg_x0_reg, cfg_y0_reg, cfg_width_reg, cfg_height_reg;

  logic              sample_cfg, start_accept, frame_end;
  logic              zero_dims_in;
  logic [DIM_W-1:0]  x_adv, y_adv, remaining;
  logic [ADDR_W-1:0] row_idx, col_idx, base_sel;

  assign zero_dims_in = (i_wire_width == '0) || (i_wire_height == '0);
  assign row_idx      = ADDR_W'(cfg_y0_reg) + ADDR_W'(y_reg);
  assign col_idx      = ADDR_W'(cfg_x0_reg) + ADDR_W'(x_reg);
  assign remaining    = cfg_width_reg - x_reg;

`ifdef PAINTERENGINE_GPU_FRAMESTREAMER_DOUBLE_BUFFER_EN
  logic [ADDR_W-1:0] cfg_base1_reg;
  logic              buffer_index_reg;

  assign base_sel            = buffer_index_reg ? cfg_base1_reg : cfg_base_reg;
  assign o_wire_buffer_index = buffer_index_reg;

  // Index flips at every frame end so a continuous restart reads the other buffer.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      cfg_base1_reg    <= '0;
      buffer_index_reg <= 1'b0;
    end else begin
      if (sample_cfg) cfg_base1_reg <= i_wire_base_address1;
      if (start_accept) buffer_index_reg <= 1'b0;
      else if (frame_end) buffer_index_reg <= ~buffer_index_reg;
    end
  end
`else
  assign base_sel = cfg_base_reg;
`endif

  always_comb begin
    state_next       = state_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    row_off_next     = row_off_reg;
    col_off_next     = col_off_reg;
    address_next     = address_reg;
    length_next      = length_reg;
    frame_done_next  = 1'b0;
    frame_count_next = frame_count_reg;
    sample_cfg       = 1'b0;
    start_accept     = 1'b0;
    frame_end        = 1'b0;
    x_adv            = x_reg + length_reg;
    y_adv            = y_reg;

    if (i_wire_stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_wire_start) begin
            start_accept     = 1'b1;
            sample_cfg       = 1'b1;
            x_next           = '0;
            y_next           = '0;
            frame_count_next = '0;
            if (zero_dims_in) begin
              state_next      = ST_DONE;
              frame_done_next = 1'b1;
            end else begin
              state_next = ST_CALC1;
            end
          end
        end
        ST_CALC1: begin
          row_off_next = row_idx * cfg_stride_reg;
          col_off_next = col_idx * ADDR_W'(BPP_BYTES);
          state_next   = ST_CALC2;
        end
        ST_CALC2: begin
          address_next = base_sel + row_off_reg + col_off_reg;
          length_next  = (remaining > DIM_W'(BLOCK_SIZE)) ? DIM_W'(BLOCK_SIZE) : remaining;
          state_next   = ST_WAIT;
        end
        ST_WAIT: begin
          if (reader.fifo_empty_count >= CNT_W'(LAUNCH_SIZE)) state_next = ST_STREAM;
        end
        ST_STREAM: begin
          // Error takes priority over a done reported in the same cycle.
          if (reader.reader_error) state_next = ST_ERROR;
          else if (reader.reader_done) state_next = ST_CHECK;
        end
        ST_CHECK: begin
          if (x_adv == cfg_width_reg) begin
            x_next = '0;
            y_adv  = y_reg + DIM_W'(1);
          end else begin
            x_next = x_adv;
          end
          y_next = y_adv;
          if (y_adv == cfg_height_reg) begin
            frame_end        = 1'b1;
            frame_done_next  = 1'b1;
            frame_count_next = frame_count_reg + 16'd1;
            x_next           = '0;
            y_next           = '0;
            if (i_wire_continuous) begin
              sample_cfg = 1'b1;
              state_next = zero_dims_in ? ST_DONE : ST_CALC1;
            end else begin
              state_next = ST_DONE;
            end
          end else begin
            state_next = ST_CALC1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_reg       <= ST_IDLE;
      x_reg           <= '0;
      y_reg           <= '0;
      row_off_reg     <= '0;
      col_off_reg     <= '0;
      address_reg     <= '0;
      length_reg      <= '0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
      cfg_base_reg    <= '0;
      cfg_stride_reg  <= '0;
      cfg_x0_reg      <= '0;
      cfg_y0_reg      <= '0;
      cfg_width_reg   <= '0;
      cfg_height_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      row_off_reg     <= row_off_next;
      col_off_reg     <= col_off_next;
      address_reg     <= address_next;
      length_reg      <= length_next;
      frame_done_reg  <= frame_done_next;
      frame_count_reg <= frame_count_next;
      if (sample_cfg) begin
        cfg_base_reg   <= i_wire_base_address;
        cfg_stride_reg <= i_wire_stride;
        cfg_x0_reg     <= i_wire_x0;
        cfg_y0_reg     <= i_wire_y0;
        cfg_width_reg  <= i_wire_width;
        cfg_height_reg <= i_wire_height;
      end
    end
  end

  // Enable is gated by reset and stop directly so the reader is released without waiting a clock.
  assign reader.reader_resetn  = i_wire_resetn && !i_wire_stop && (state_reg == ST_STREAM);
  assign reader.reader_address = address_reg;
  assign reader.reader_length  = 32'(length_reg);

  assign o_wire_state       = state_reg;
  assign o_wire_busy        = !((state_reg == ST_IDLE) || (state_reg == ST_DONE) || (state_reg == ST_ERROR));
  assign o_wire_frame_done  = frame_done_reg;
  assign o_wire_frame_count = frame_count_reg;

endmodule

// File: tb/tb_painterengine_gpu_framestreamer.sv
// Directed and randomized bench for the frame streamer; expected bursts come from a viewport-walk model.
module tb_painterengine_gpu_framestreamer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, stop, continuous;
  logic [31:0] base, stride;
  logic [15:0] x0, y0, w, h;
  logic [2:0]  state;
  logic        busy, frame_done;
  logic [15:0] frame_count;
`ifdef PAINTERENGINE_GPU_FRAMESTREAMER_DOUBLE_BUFFER_EN
  logic [31:0] base1;
  logic        buffer_index;
`endif

  always #5 clk = ~clk;

  painterengine_gpu_framestreamer_if #(.ADDR_W(32), .CNT_W(8)) bus ();

  painterengine_gpu_framestreamer dut (
    .i_wire_clock        (clk),
    .i_wire_resetn       (rst_n),
    .i_wire_start        (start),
    .i_wire_stop         (stop),
    .i_wire_continuous   (continuous),
    .i_wire_base_address (base),
`ifdef PAINTERENGINE_GPU_FRAMESTREAMER_DOUBLE_BUFFER_EN
    .i_wire_base_address1(base1),
    .o_wire_buffer_index (buffer_index),
`endif
    .i_wire_stride       (stride),
    .i_wire_x0           (x0),
    .i_wire_y0           (y0),
    .i_wire_width        (w),
    .i_wire_height       (h),
    .reader              (bus),
    .o_wire_state        (state),
    .o_wire_busy         (busy),
    .o_wire_frame_done   (frame_done),
    .o_wire_frame_count  (frame_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int fd_cnt = 0;
  int rh_cnt = 0;
  bit rand_fifo = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_len[$];

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (bus.reader_resetn === 1'b1) rh_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Reference: every row of the viewport split into BLOCK_SIZE-pixel segments, 4 bytes per pixel.
  task automatic build_exp(input int unsigned b, input int unsigned s, input int unsigned vx,
                           input int unsigned vy, input int unsigned vw, input int unsigned vh);
    exp_addr.delete();
    exp_len.delete();
    for (int unsigned r = 0; r < vh; r++) begin
      for (int unsigned px = 0; px < vw; px += 64) begin
        exp_addr.push_back(b + (vy + r) * s + (vx + px) * 4);
        exp_len.push_back((vw - px) < 64 ? (vw - px) : 64);
      end
    end
  endtask

  task automatic wait_resetn(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.reader_resetn === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (rand_fifo) bus.fifo_empty_count = 8'($urandom_range(30, 128));
      tick(1);
    end
    if (!ok) check({tag, "_timeout"}, 64'(bus.reader_resetn), 64'd1);
  endtask

  task automatic serve_burst(input string tag, input logic [31:0] ea, input logic [31:0] el,
                             input bit err);
    bit ok;
    wait_resetn(tag, ok);
    if (!ok) return;
    check({tag, "_addr"}, 64'(bus.reader_address), 64'(ea));
    check({tag, "_len"}, 64'(bus.reader_length), 64'(el));
    $display("burst %s addr=%0h len=%0d", tag, bus.reader_address, bus.reader_length);
    tick(int'($urandom_range(0, 3)));
    bus.reader_done = 1'b1;
    bus.reader_error = err;
    tick(1);
    bus.reader_done = 1'b0;
    bus.reader_error = 1'b0;
  endtask

  task automatic serve_all(input string tag);
    while (exp_addr.size() > 0) serve_burst(tag, exp_addr.pop_front(), exp_len.pop_front(), 1'b0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target);
    for (int i = 0; i < 100; i++) begin
      if (state === target) break;
      tick(1);
    end
    check(tag, 64'(state), 64'(target));
  endtask

  initial begin
    bit ok;
    int fd_before;
    start = 0; stop = 0; continuous = 0;
    base = 32'h1000; stride = 512; x0 = 0; y0 = 0; w = 100; h = 2;
`ifdef PAINTERENGINE_GPU_FRAMESTREAMER_DOUBLE_BUFFER_EN
    base1 = 32'h8000;
`endif
    bus.reader_done = 0; bus.reader_error = 0; bus.fifo_empty_count = 8'd128;
    tick(3);
    check("rst_state", 64'(state), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resetn", 64'(bus.reader_resetn), 64'd0);
    check("rst_addr", 64'(bus.reader_address), 64'd0);
    check("rst_len", 64'(bus.reader_length), 64'd0);
    check("rst_fdone", 64'(frame_done), 64'd0);
    check("rst_fcount", 64'(frame_count), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Directed 100x2 frame with start-to-enable latency.
    fd_cnt = 0;
    build_exp(32'h1000, 512, 0, 0, 100, 2);
    do_start();
    tick(2);
    check("lat_wait_state", 64'(state), 64'd3);
    check("lat_resetn_low", 64'(bus.reader_resetn), 64'd0);
    tick(1);
    check("lat_resetn_high", 64'(bus.reader_resetn), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    serve_burst("t1_b0", 32'h1000, 64, 1'b0);
    serve_burst("t1_b1", 32'h1100, 36, 1'b0);
    serve_burst("t1_b2", 32'h1200, 64, 1'b0);
    serve_burst("t1_b3", 32'h1300, 36, 1'b0);
    exp_addr.delete(); exp_len.delete();
    wait_state("t1_done", 3'd6);
    tick(2);
    check("t1_fdone_cnt", 64'(fd_cnt), 64'd1);
    check("t1_fcount", 64'(frame_count), 64'd1);

    // Viewport offset.
    base = 0; stride = 512; x0 = 4; y0 = 1; w = 8; h = 1;
    do_start();
    serve_burst("t2_b0", 32'h210, 8, 1'b0);
    wait_state("t2_done", 3'd6);

    // FIFO gating at the launch threshold.
    bus.fifo_empty_count = 8'd47;
    do_start();
    tick(2);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("t3_hold_resetn", 64'(bus.reader_resetn), 64'd0);
      check("t3_hold_state", 64'(state), 64'd3);
    end
    bus.fifo_empty_count = 8'd48;
    tick(1);
    check("t3_launch", 64'(bus.reader_resetn), 64'd1);
    serve_burst("t3_b0", 32'h210, 8, 1'b0);
    wait_state("t3_done", 3'd6);
    bus.fifo_empty_count = 8'd128;

    // Error with simultaneous done on the second burst, then restart and stop mid-stream.
    base = 32'h1000; stride = 512; x0 = 0; y0 = 0; w = 100; h = 2;
    tick(1);
    fd_cnt = 0;
    do_start();
    serve_burst("t4_b0", 32'h1000, 64, 1'b0);
    serve_burst("t4_b1", 32'h1100, 36, 1'b1);
    check("t4_err_state", 64'(state), 64'd7);
    check("t4_err_resetn", 64'(bus.reader_resetn), 64'd0);
    check("t4_err_busy", 64'(busy), 64'd0);
    tick(5);
    check("t4_err_sticky", 64'(state), 64'd7);
    do_start();
    wait_resetn("t4_restart", ok);
    check("t4_restart_addr", 64'(bus.reader_address), 64'h1000);
    stop = 1'b1;
    #1;
    check("t4_stop_resetn", 64'(bus.reader_resetn), 64'd0);
    tick(1);
    stop = 1'b0;
    check("t4_stop_state", 64'(state), 64'd0);
    tick(2);
    check("t4_no_fdone", 64'(fd_cnt), 64'd0);

    // Continuous streaming for three frames.
    continuous = 1; base = 32'h2000; stride = 256; w = 64; h = 1;
    tick(1);
    fd_cnt = 0;
    do_start();
    for (int f = 0; f < 3; f++) begin
`ifdef PAINTERENGINE_GPU_FRAMESTREAMER_DOUBLE_BUFFER_EN
      serve_burst("t5_frame", (f % 2) ? 32'h8000 : 32'h2000, 64, 1'b0);
`else
      serve_burst("t5_frame", 32'h2000, 64, 1'b0);
`endif
    end
    wait_resetn("t5_fourth", ok);
    check("t5_fdone_cnt", 64'(fd_cnt), 64'd3);
    check("t5_fcount", 64'(frame_count), 64'd3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t5_stop_state", 64'(state), 64'd0);
    continuous = 0;
    tick(2);

    // Empty viewport: frame completes without any burst.
    w = 0; h = 5;
    fd_cnt = 0; rh_cnt = 0;
    do_start();
    tick(5);
    check("t6_state", 64'(state), 64'd6);
    check("t6_fdone_cnt", 64'(fd_cnt), 64'd1);
    check("t6_no_enable", 64'(rh_cnt), 64'd0);

    // Random viewports with random FIFO levels and reader latency.
    rand_fifo = 1;
    for (int t = 0; t < 6; t++) begin
      base = $urandom & 32'hFFFF_FFFC;
      stride = $urandom_range(256, 4096);
      x0 = 16'($urandom_range(0, 20));
      y0 = 16'($urandom_range(0, 20));
      w = 16'($urandom_range(1, 150));
      h = 16'($urandom_range(1, 3));
      build_exp(base, stride, x0, y0, w, h);
      tick(1);
      fd_before = fd_cnt;
      do_start();
      serve_all("rnd");
      wait_state("rnd_done", 3'd6);
      tick(2);
      check("rnd_fdone", 64'(fd_cnt), 64'(fd_before + 1));
      check("rnd_fcount", 64'(frame_count), 64'd1);
    end
    rand_fifo = 0;
    bus.fifo_empty_count = 8'd128;

    // Asynchronous reset during a burst.
    base = 32'h1000; stride = 512; x0 = 0; y0 = 0; w = 100; h = 1;
    do_start();
    wait_resetn("t8_enable", ok);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_resetn", 64'(bus.reader_resetn), 64'd0);
    check("t8_rst_state", 64'(state), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
